lcd_timing_gen: RTL and testbench
=================================

# lcd_timing_gen

Parametrised two-axis LCD/RGB timing generator. It produces the horizontal and vertical sync, the data enable, and active-area pixel coordinates for an entire frame, and adds a run/stop control. It also issues a look-ahead pixel request `RD_LAT` cycles before `lcd_de`, so that a frame buffer or waveform RAM with fixed read latency can be addressed in time. It sits between the pixel-clock domain display driver and the scope/DDS rendering memory.

## Interface
- `H_SYNC`, 1: horizontal sync width, in pixel clocks.
- `H_BACK`, 46: horizontal back porch.
- `H_VALID`, 800: active pixels per line.
- `H_FRONT`, 210: horizontal front porch.
- `V_SYNC`, 1: vertical sync width, in lines.
- `V_BACK`, 23: vertical back porch.
- `V_VALID`, 480: active lines.
- `V_FRONT`, 22: vertical front porch.
- `HS_POL`, 0: active level of `lcd_hs`.
- `VS_POL`, 0: active level of `lcd_vs`.
- `RD_LAT`, 2: request lead in cycles. Legal range 0..H_SYNC+H_BACK.
- `CNT_W`, 11: counter and coordinate width. H_TOTAL and V_TOTAL must each be ≤ 2^CNT_W.
- `lcd_clk` in 1: pixel clock, the only clock.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `lcd_en` in 1: run request, level-sensitive.
- `busy` out 1: generator in RUN state.
- `lcd_hs` out 1: horizontal sync.
- `lcd_vs` out 1: vertical sync.
- `lcd_de` out 1: data enable, high only where both axes are active.
- `pixel_xpos` out CNT_W: active column aligned with `lcd_de`. 0 when `lcd_de` is 0.
- `pixel_ypos` out CNT_W: active row aligned with `lcd_de`. 0 when `lcd_de` is 0.
- `data_req` out 1: look-ahead pixel request.
- `req_xpos` out CNT_W: column being requested. 0 when `data_req` is 0.
- `req_ypos` out CNT_W: row being requested. 0 when `data_req` is 0.
- `frame_start` out 1: one-cycle pulse at counter (0,0).
- `line_start` out 1: one-cycle pulse at h = 0.

## Operation
- **Derived constants**
  - H_TOTAL = sum of the four H parameters; V_TOTAL likewise.
  - Line order is SYNC, BACK, VALID, FRONT, counted from 0.
  - HA = H_SYNC+H_BACK; VA = V_SYNC+V_BACK.
- **IDLE state**
  - h_cnt = v_cnt = 0.
  - All outputs held inactive: `lcd_hs`=~HS_POL, `lcd_vs`=~VS_POL, all others 0.
  - `lcd_en`=1 sampled in IDLE → RUN.
- **RUN state**
  - h_cnt increments every cycle and wraps at H_TOTAL-1.
  - v_cnt increments on h wrap and wraps at V_TOTAL-1.
- **Stop**
  - `lcd_en` is re-evaluated only at the last count of a frame (h=H_TOTAL-1, v=V_TOTAL-1).
  - If `lcd_en` is 0 there → IDLE, counters to 0. Otherwise the next frame starts.
  - Dropping `lcd_en` mid-frame always completes that frame. Frames are never truncated.
- **Decode (registered)** from counter (h,v) in RUN:
  - `lcd_hs` active when h<H_SYNC.
  - `lcd_vs` active when v<V_SYNC.
  - `lcd_de` when HA≤h<HA+H_VALID and VA≤v<VA+V_VALID.
  - `pixel_xpos`=h-HA, `pixel_ypos`=v-VA.
  - `data_req` when HA≤h+RD_LAT<HA+H_VALID and v active.
  - `req_xpos`=h+RD_LAT-HA, `req_ypos`=v-VA.
  - The request never crosses a line boundary, guaranteed by the `RD_LAT` range.
- **Arithmetic**
  - Unsigned, CNT_W bits.
  - h+RD_LAT is evaluated in CNT_W+1 bits.
- **Reset**
  - Asynchronous reset at any time → IDLE, counters 0, outputs at their IDLE values.
  - The first frame after reset requires `lcd_en`.

## Timing
- `lcd_en` sampled 1 at cycle k in IDLE → RUN with (h,v)=(0,0) at k+1.
- `busy`=1 from k+1 to the cycle after the final count of the last frame.
- Counter value at cycle n → all decoded outputs at n+1. Single-register latency for every output.
- `frame_start` first appears at k+2.
- `data_req`/`req_*` lead `lcd_de`/`pixel_*` by exactly `RD_LAT` cycles.
- With `RD_LAT`=0, `data_req` is identical to `lcd_de`.
- Period between `frame_start` pulses: H_TOTAL×V_TOTAL cycles.
- Period between `line_start` pulses: H_TOTAL cycles.

## Structure
- Package `lcd_timing_pkg` contains:
  - state enum {IDLE, RUN};
  - default 800×480 timing constants;
  - a legality-check function for `RD_LAT` and totals vs `CNT_W`.
- Sub-module `lcd_axis_timing` (SYNC/BACK/VALID/FRONT, `inc` input) is instantiated twice, once for H and once for V. Each instance provides:
  - a counter;
  - wrap;
  - sync/active flags;
  - position.
- Top level holds the FSM, the look-ahead compare and the output registers.

## Test plan
Small configuration used in all scenarios unless stated: H 2/3/8/4 (total 17), V 1/2/4/1 (total 8), `RD_LAT`=2.

- **Reset:** assert `sys_rst_n`=0 → `lcd_hs`=`lcd_vs`=1, `lcd_de`=`data_req`=`busy`=0, all positions 0.
- **Start:**
  - `lcd_en`=1 at cycle k → `frame_start` at k+2.
  - First `data_req` at k+56 with `req_xpos`=0, `req_ypos`=0.
  - First `lcd_de` at k+58 with `pixel_xpos`=0.
- **Full frame:**
  - Each of 4 rows shows `pixel_xpos` 0..7 contiguous with `lcd_de`, and `pixel_ypos` 0..3.
  - `frame_start` repeats every 136 cycles.
  - `lcd_hs` is low for 2 cycles per line; `lcd_vs` is low for 17 cycles per frame.
- **Graceful stop:** drop `lcd_en` mid-frame → frame completes with 32 `lcd_de` cycles, `busy` falls, no further `frame_start`.
- **Reset mid-frame:** assert `sys_rst_n`=0 during an active line → all outputs return to IDLE values immediately. After release with `lcd_en`=1, the next frame begins at (0,0).
- **Mode variants:** with `RD_LAT`=0, `HS_POL`=1, `VS_POL`=1:
  - `data_req` equals `lcd_de` every cycle;
  - `lcd_hs`/`lcd_vs` idle at 0 and pulse high.

Source files
------------

// File: rtl/lcd_timing_pkg.sv
// Shared types, default 800x480 timing and configuration legality check
// for the LCD timing generator.
package lcd_timing_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } lcd_state_e;

    localparam int DEF_H_SYNC  = 1;
    localparam int DEF_H_BACK  = 46;
    localparam int DEF_H_VALID = 800;
    localparam int DEF_H_FRONT = 210;
    localparam int DEF_V_SYNC  = 1;
    localparam int DEF_V_BACK  = 23;
    localparam int DEF_V_VALID = 480;
    localparam int DEF_V_FRONT = 22;
    localparam int DEF_RD_LAT  = 2;
    localparam int DEF_CNT_W   = 11;

    // The look-ahead must stay inside the line and both totals must fit the counters.
    function automatic bit lcd_cfg_ok(
        input int h_sync, input int h_back, input int h_valid, input int h_front,
        input int v_sync, input int v_back, input int v_valid, input int v_front,
        input int rd_lat, input int cnt_w
    );
        longint h_total;
        longint v_total;
        longint limit;
        h_total = longint'(h_sync) + h_back + h_valid + h_front;
        v_total = longint'(v_sync) + v_back + v_valid + v_front;
        limit   = longint'(1) << cnt_w;
        return (rd_lat >= 0) && (rd_lat <= h_sync + h_back) &&
               (h_total > 0) && (v_total > 0) &&
               (h_total <= limit) && (v_total <= limit);
    endfunction

endpackage

// File: rtl/lcd_timing_if.sv
// Timing generator bus: run control in, sync/enable/position/request out.
// All signals are sampled on the rising edge of lcd_clk; there is no handshake back-pressure.
interface lcd_timing_if
    import lcd_timing_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             lcd_en;
    logic             busy;
    logic             lcd_hs;
    logic             lcd_vs;
    logic             lcd_de;
    logic [CNT_W-1:0] pixel_xpos;
    logic [CNT_W-1:0] pixel_ypos;
    logic             data_req;
    logic [CNT_W-1:0] req_xpos;
    logic [CNT_W-1:0] req_ypos;
    logic             frame_start;
    logic             line_start;
    lcd_state_e       dbg_state;

    modport master (
        input  lcd_en,
        output busy, lcd_hs, lcd_vs, lcd_de, pixel_xpos, pixel_ypos,
        output data_req, req_xpos, req_ypos, frame_start, line_start, dbg_state
    );

    modport slave (
        output lcd_en,
        input  busy, lcd_hs, lcd_vs, lcd_de, pixel_xpos, pixel_ypos,
        input  data_req, req_xpos, req_ypos, frame_start, line_start, dbg_state
    );

endinterface

// File: rtl/lcd_axis_timing.sv
// One display axis: SYNC/BACK/VALID/FRONT counter with wrap, sync/active
// flags and active-area position, all decoded combinationally from the count.
module lcd_axis_timing
    import lcd_timing_pkg::*;
#(
    parameter int SYNC  = DEF_H_SYNC,
    parameter int BACK  = DEF_H_BACK,
    parameter int VALID = DEF_H_VALID,
    parameter int FRONT = DEF_H_FRONT,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             last,
    output logic             sync,
    output logic             active,
    output logic [CNT_W-1:0] pos
);
    localparam int TOTAL = SYNC + BACK + VALID + FRONT;
    localparam int ACT_LO = SYNC + BACK;
    localparam int ACT_HI = SYNC + BACK + VALID;

    logic [CNT_W:0] cnt_x;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

    // Compare one bit wider so an active area ending exactly at 2^CNT_W still works.
    assign cnt_x  = {1'b0, cnt};
    assign last   = (cnt == CNT_W'(TOTAL - 1));
    assign sync   = (cnt_x < (CNT_W+1)'(SYNC));
    assign active = (cnt_x >= (CNT_W+1)'(ACT_LO)) && (cnt_x < (CNT_W+1)'(ACT_HI));
    assign pos    = cnt - CNT_W'(ACT_LO);

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD/RGB frame timing generator: run/stop FSM, H/V axis counters,
// registered sync/DE/position decode and an RD_LAT-cycle look-ahead pixel request.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_SYNC  = DEF_H_SYNC,
    parameter int H_BACK  = DEF_H_BACK,
    parameter int H_VALID = DEF_H_VALID,
    parameter int H_FRONT = DEF_H_FRONT,
    parameter int V_SYNC  = DEF_V_SYNC,
    parameter int V_BACK  = DEF_V_BACK,
    parameter int V_VALID = DEF_V_VALID,
    parameter int V_FRONT = DEF_V_FRONT,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0,
    parameter int RD_LAT  = DEF_RD_LAT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic         lcd_clk,
    input  logic         sys_rst_n,
    lcd_timing_if.master bus
);
    localparam int HA = H_SYNC + H_BACK;
    localparam int HA_END = H_SYNC + H_BACK + H_VALID;
    localparam bit CFG_OK = lcd_cfg_ok(H_SYNC, H_BACK, H_VALID, H_FRONT,
                                       V_SYNC, V_BACK, V_VALID, V_FRONT, RD_LAT, CNT_W);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_RUN  = RUN;

    if (!CFG_OK) begin : g_bad_cfg
        $error("lcd_timing_gen: illegal RD_LAT or totals exceed counter width");
    end

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic             run;
    logic [CNT_W-1:0] h_cnt, v_cnt, h_pos, v_pos;
    logic             h_last, v_last, h_sync, v_sync, h_act, v_act;
    logic [CNT_W:0]   h_ahead;
    logic             req_hit;

    logic             hs_q, vs_q, de_q, req_q, fs_q, ls_q;
    logic [CNT_W-1:0] px_q, py_q, rx_q, ry_q;

    assign run = (state_q == ST_RUN);

    // lcd_en only matters in IDLE and at the final count of a frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.lcd_en) state_d = ST_RUN;
            ST_RUN:  if (h_last && v_last && !bus.lcd_en) state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    lcd_axis_timing #(
        .SYNC(H_SYNC), .BACK(H_BACK), .VALID(H_VALID), .FRONT(H_FRONT), .CNT_W(CNT_W)
    ) u_h_axis (
        .clk(lcd_clk), .rst_n(sys_rst_n), .clr(!run), .inc(run),
        .cnt(h_cnt), .last(h_last), .sync(h_sync), .active(h_act), .pos(h_pos)
    );

    lcd_axis_timing #(
        .SYNC(V_SYNC), .BACK(V_BACK), .VALID(V_VALID), .FRONT(V_FRONT), .CNT_W(CNT_W)
    ) u_v_axis (
        .clk(lcd_clk), .rst_n(sys_rst_n), .clr(!run), .inc(run && h_last),
        .cnt(v_cnt), .last(v_last), .sync(v_sync), .active(v_act), .pos(v_pos)
    );

    assign h_ahead = {1'b0, h_cnt} + (CNT_W+1)'(RD_LAT);
    assign req_hit = (h_ahead >= (CNT_W+1)'(HA)) && (h_ahead < (CNT_W+1)'(HA_END)) && v_act;

    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            de_q  <= 1'b0;
            req_q <= 1'b0;
            fs_q  <= 1'b0;
            ls_q  <= 1'b0;
            px_q  <= '0;
            py_q  <= '0;
            rx_q  <= '0;
            ry_q  <= '0;
        end else if (run) begin
            hs_q  <= h_sync ? HS_POL : ~HS_POL;
            vs_q  <= v_sync ? VS_POL : ~VS_POL;
            de_q  <= h_act && v_act;
            req_q <= req_hit;
            fs_q  <= (h_cnt == '0) && (v_cnt == '0);
            ls_q  <= (h_cnt == '0);
            px_q  <= (h_act && v_act) ? h_pos : '0;
            py_q  <= (h_act && v_act) ? v_pos : '0;
            rx_q  <= req_hit ? (h_cnt + CNT_W'(RD_LAT) - CNT_W'(HA)) : '0;
            ry_q  <= req_hit ? v_pos : '0;
        end else begin
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            de_q  <= 1'b0;
            req_q <= 1'b0;
            fs_q  <= 1'b0;
            ls_q  <= 1'b0;
            px_q  <= '0;
            py_q  <= '0;
            rx_q  <= '0;
            ry_q  <= '0;
        end
    end

    assign bus.busy        = run;
    assign bus.lcd_hs      = hs_q;
    assign bus.lcd_vs      = vs_q;
    assign bus.lcd_de      = de_q;
    assign bus.pixel_xpos  = px_q;
    assign bus.pixel_ypos  = py_q;
    assign bus.data_req    = req_q;
    assign bus.req_xpos    = rx_q;
    assign bus.req_ypos    = ry_q;
    assign bus.frame_start = fs_q;
    assign bus.line_start  = ls_q;
    assign bus.dbg_state   = lcd_state_e'(state_q);

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen on the small 17x8 timing: scoreboard of expected
// DE/request/frame events plus directed reset, start, stop and polarity steps.
module tb_lcd_timing_gen;
    import lcd_timing_pkg::*;

    localparam int CW = 11;
    localparam int HT = 17;
    localparam int FT = 136;
    localparam int HA = 5;
    localparam int VA = 3;
    localparam int HV = 8;
    localparam int VV = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lcd_timing_if #(.CNT_W(CW)) a_if ();
    lcd_timing_if #(.CNT_W(CW)) b_if ();

    lcd_timing_gen #(
        .H_SYNC(2), .H_BACK(3), .H_VALID(8), .H_FRONT(4),
        .V_SYNC(1), .V_BACK(2), .V_VALID(4), .V_FRONT(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .RD_LAT(2), .CNT_W(CW)
    ) dut_a (.lcd_clk(clk), .sys_rst_n(rst_n), .bus(a_if));

    lcd_timing_gen #(
        .H_SYNC(2), .H_BACK(3), .H_VALID(8), .H_FRONT(4),
        .V_SYNC(1), .V_BACK(2), .V_VALID(4), .V_FRONT(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .RD_LAT(0), .CNT_W(CW)
    ) dut_b (.lcd_clk(clk), .sys_rst_n(rst_n), .bus(b_if));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err = 0;
    logic [53:0] exp_q[$];
    logic [53:0] req_exp_q[$];
    logic [53:0] b_exp_q[$];
    int fs_q[$];
    bit mon_on = 1'b0;
    bit mon_b = 1'b0;
    int k_ref = 0;
    int hs_low, vs_low, line_cnt, b_hs_hi, b_vs_hi;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_frame(input int k0, input int f);
        int t;
        for (int y = 0; y < VV; y++) begin
            for (int x = 0; x < HV; x++) begin
                t = k0 + 2 + f * FT + (y + VA) * HT + (x + HA);
                exp_q.push_back({32'(t), 11'(x), 11'(y)});
                b_exp_q.push_back({32'(t), 11'(x), 11'(y)});
                req_exp_q.push_back({32'(t - 2), 11'(x), 11'(y)});
            end
        end
        fs_q.push_back(k0 + 2 + f * FT);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_hs"}, a_if.lcd_hs, 1'b1);
        check({tag, "_vs"}, a_if.lcd_vs, 1'b1);
        check({tag, "_de"}, a_if.lcd_de, 1'b0);
        check({tag, "_req"}, a_if.data_req, 1'b0);
        check({tag, "_busy"}, a_if.busy, 1'b0);
        check({tag, "_pos"}, {a_if.pixel_xpos, a_if.pixel_ypos, a_if.req_xpos, a_if.req_ypos}, 0);
        check({tag, "_pulses"}, {a_if.frame_start, a_if.line_start}, 0);
        check({tag, "_state"}, a_if.dbg_state, IDLE);
        check({tag, "_b_hs"}, b_if.lcd_hs, 1'b0);
        check({tag, "_b_vs"}, b_if.lcd_vs, 1'b0);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Scoreboard: pop an expected entry whenever the DUT presents an event.
    always @(negedge clk) begin
        logic [53:0] e;
        int fs_exp;
        if (mon_on) begin
            if (a_if.lcd_de) begin
                check("de_expected", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("de_event", {32'(cyc), a_if.pixel_xpos, a_if.pixel_ypos}, e);
                end
            end else begin
                check("de_off_pos", {a_if.pixel_xpos, a_if.pixel_ypos}, 0);
            end
            if (a_if.data_req) begin
                check("req_expected", 64'(req_exp_q.size() != 0), 1);
                if (req_exp_q.size() != 0) begin
                    e = req_exp_q.pop_front();
                    check("req_event", {32'(cyc), a_if.req_xpos, a_if.req_ypos}, e);
                end
            end else begin
                check("req_off_pos", {a_if.req_xpos, a_if.req_ypos}, 0);
            end
            if (a_if.frame_start) begin
                check("fs_expected", 64'(fs_q.size() != 0), 1);
                if (fs_q.size() != 0) begin
                    fs_exp = fs_q.pop_front();
                    check("fs_cycle", cyc, fs_exp);
                end
            end
            if (a_if.line_start) begin
                line_cnt++;
                check("ls_phase", (cyc - k_ref - 2) % HT, 0);
            end
            if (!a_if.lcd_hs) hs_low++;
            if (!a_if.lcd_vs) vs_low++;
            if (mon_b) begin
                check("b_req_eq_de", b_if.data_req, b_if.lcd_de);
                check("b_req_pos", {b_if.req_xpos, b_if.req_ypos}, {b_if.pixel_xpos, b_if.pixel_ypos});
                if (b_if.lcd_de) begin
                    check("b_de_expected", 64'(b_exp_q.size() != 0), 1);
                    if (b_exp_q.size() != 0) begin
                        e = b_exp_q.pop_front();
                        check("b_de_event", {32'(cyc), b_if.pixel_xpos, b_if.pixel_ypos}, e);
                    end
                end
                if (b_if.lcd_hs) b_hs_hi++;
                if (b_if.lcd_vs) b_vs_hi++;
            end
        end
    end

    initial begin
        int k;
        int r;
        rst_n = 1'b0;
        a_if.lcd_en = 1'b0;
        b_if.lcd_en = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");

        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_idle("no_en");

        // Two frames, lcd_en dropped in the middle of the second.
        hs_low = 0; vs_low = 0; line_cnt = 0; b_hs_hi = 0; b_vs_hi = 0;
        k = cyc;
        k_ref = k;
        push_frame(k, 0);
        push_frame(k, 1);
        mon_on = 1'b1;
        mon_b = 1'b1;
        a_if.lcd_en = 1'b1;
        b_if.lcd_en = 1'b1;
        wait_until(k + 1);
        check("busy_start", a_if.busy, 1'b1);
        check("idle_out_k1", a_if.lcd_hs, 1'b1);
        wait_until(k + FT + 60);
        a_if.lcd_en = 1'b0;
        b_if.lcd_en = 1'b0;
        wait_until(k + 2 * FT);
        check("busy_last_count", a_if.busy, 1'b1);
        wait_until(k + 2 * FT + 1);
        check("busy_fall", a_if.busy, 1'b0);
        wait_until(k + 2 * FT + 150);
        mon_on = 1'b0;
        mon_b = 1'b0;
        check("stop_de_left", exp_q.size(), 0);
        check("stop_req_left", req_exp_q.size(), 0);
        check("stop_fs_left", fs_q.size(), 0);
        check("b_de_left", b_exp_q.size(), 0);
        check("hs_low_cycles", hs_low, 32);
        check("vs_low_cycles", vs_low, 34);
        check("line_starts", line_cnt, 16);
        check("b_hs_high_cycles", b_hs_hi, 32);
        check("b_vs_high_cycles", b_vs_hi, 34);
        check_idle("after_stop");

        // Reset during an active line, then restart from (0,0).
        k = cyc;
        a_if.lcd_en = 1'b1;
        b_if.lcd_en = 1'b1;
        wait_until(k + 60);
        check("mid_line_de", a_if.lcd_de, 1'b1);
        check("mid_line_x", a_if.pixel_xpos, 2);
        #2 rst_n = 1'b0;
        #1 check_idle("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        r = cyc;
        k_ref = r;
        hs_low = 0; vs_low = 0; line_cnt = 0;
        push_frame(r, 0);
        mon_on = 1'b1;
        wait_until(r + 5);
        a_if.lcd_en = 1'b0;
        b_if.lcd_en = 1'b0;
        wait_until(r + FT + 60);
        mon_on = 1'b0;
        check("restart_de_left", exp_q.size(), 0);
        check("restart_req_left", req_exp_q.size(), 0);
        check("restart_fs_left", fs_q.size(), 0);
        check("restart_lines", line_cnt, 8);
        check("restart_hs_low", hs_low, 16);
        check("restart_vs_low", vs_low, 17);
        check_idle("restart_end");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
